// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types.
// Owner state encoding and default hold limit.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CORE = 2'd1,
        ARB_DMA  = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_MAX_HOLD = 8;

endpackage

// File: rtl/dmem_arbiter_hold_cnt.sv
// Saturating hold counter for dmem_arbiter.
// limit flags the last allowed contended cycle.
module arb_hold_cnt
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic limit
);

    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign limit = (cnt_q == CW'(MAX_HOLD - 1));

    // Clear wins; otherwise count up and stick at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !limit) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/secondary arbiter for the single-port data memory.
// Core wins from idle; hold counter bounds starvation.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_gnt,
    output logic          stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_gnt,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       hold_clr;
    logic       hold_inc;
    logic       hold_limit;

    arb_hold_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk   (clk),
        .reset (reset),
        .clr   (hold_clr),
        .inc   (hold_inc),
        .limit (hold_limit)
    );

    // Grants, memory mux and read-data steering; all gated by reset.
    always_comb begin
        c_gnt   = (state_q == ARB_CORE) & c_req & reset;
        d_gnt   = (state_q == ARB_DMA) & d_req & reset;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        c_rdata = '0;
        d_rdata = '0;
        if (c_gnt) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
            c_rdata = m_rdata;
        end else if (d_gnt) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            d_rdata = m_rdata;
        end
        stall = c_req & ~c_gnt;
    end

    // Owner next state; a dropped request outranks the hold limit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (c_req) begin
                    state_d = ARB_CORE;
                end else if (d_req) begin
                    state_d = ARB_DMA;
                end
            end
            ARB_CORE: begin
                if (!c_req) begin
                    state_d = d_req ? ARB_DMA : ARB_IDLE;
                end else if (d_req && hold_limit) begin
                    state_d = ARB_DMA;
                end
            end
            ARB_DMA: begin
                if (!d_req) begin
                    state_d = c_req ? ARB_CORE : ARB_IDLE;
                end else if (c_req && hold_limit) begin
                    state_d = ARB_CORE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Hold count runs only while the owner is granted under contention.
    always_comb begin
        hold_inc = (c_gnt & d_req) | (d_gnt & c_req);
        hold_clr = !reset || (state_d != state_q) || !hold_inc;
    end

    // Owner register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter.
// Owner/streak reference model plus a behavioural memory.
module tb_dmem_arbiter;

    localparam int MAXH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic [31:0] c_rdata;
    logic        c_gnt, stall;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_gnt;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_HOLD(MAXH), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_gnt(c_gnt), .stall(stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_gnt(d_gnt),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Memory seen by the DUT (combinational read, write on edge)
    logic [31:0] dmem [0:255];
    // Reference copy updated only by the model
    logic [31:0] ref_mem [0:255];

    assign m_rdata = dmem[m_addr[9:2]];
    always @(posedge clk) if (m_we) dmem[m_addr[9:2]] <= m_wdata;

    typedef struct {
        logic        cg, dg, st, we;
        logic [31:0] addr, wd, crd, drd;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;

    // Model: who owns the memory and how long it has held it under contention
    int owner = 0;   // 0 none, 1 core, 2 secondary
    int run = 0;
    logic last_cg, last_dg;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic rst,
                        input logic cr, input logic cw,
                        input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd);
        exp_t e;
        logic cg, dg;
        int nxt;
        reset = rst;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        cg = rst && owner == 1 && cr;
        dg = rst && owner == 2 && dr;
        e.cg = cg;
        e.dg = dg;
        e.st = cr && !cg;
        e.we = cg ? cw : (dg ? dw : 1'b0);
        e.addr = cg ? ca : (dg ? da : 32'h0);
        e.wd = cg ? cd : (dg ? dd : 32'h0);
        e.crd = cg ? ref_mem[ca[9:2]] : 32'h0;
        e.drd = dg ? ref_mem[da[9:2]] : 32'h0;
        exp_q.push_back(e);
        last_cg = cg;
        last_dg = dg;
        @(posedge clk);
        if (cg && cw) ref_mem[ca[9:2]] = cd;
        if (dg && dw) ref_mem[da[9:2]] = dd;
        if (!rst) nxt = 0;
        else if (owner == 0) nxt = cr ? 1 : (dr ? 2 : 0);
        else if (owner == 1)
            nxt = !cr ? (dr ? 2 : 0) : ((dr && run + 1 >= MAXH) ? 2 : 1);
        else
            nxt = !dr ? (cr ? 1 : 0) : ((cr && run + 1 >= MAXH) ? 1 : 2);
        if (nxt != owner) run = 0;
        else if ((cg && dr) || (dg && cr)) run = run + 1;
        else run = 0;
        owner = nxt;
        #1;
    endtask

    // Monitor: compare every cycle's outputs against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("c_gnt", 32'(c_gnt), 32'(e.cg));
            chk("d_gnt", 32'(d_gnt), 32'(e.dg));
            chk("stall", 32'(stall), 32'(e.st));
            chk("m_we", 32'(m_we), 32'(e.we));
            chk("m_addr", m_addr, e.addr);
            chk("m_wdata", m_wdata, e.wd);
            chk("c_rdata", c_rdata, e.crd);
            chk("d_rdata", d_rdata, e.drd);
        end
    end

    logic        c_pend, d_pend, rcw, rdw, rrst;
    logic [31:0] rca, rcd, rda, rdd;

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i] = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        @(posedge clk);
        #1;

        // Reset held with a core store pending
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 32'h64, 32'h55, 0, 0, 0, 0);
        // Release: one stall cycle, then the store, then a load
        step(1, 1, 1, 32'h64, 32'h7, 0, 0, 0, 0);
        step(1, 1, 1, 32'h64, 32'h7, 0, 0, 0, 0);
        chk("store_mem", dmem[25], 32'h7);
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 32'h64, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Simultaneous first request then sustained contention
        for (int i = 0; i < 36; i++)
            step(1, 1, 0, 32'(i * 4), 0, 1, 0, 32'h80 + 32'(i * 4), 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Handoff when the core drops its request
        step(1, 1, 0, 32'h40, 0, 1, 0, 32'h80, 0);
        step(1, 1, 0, 32'h40, 0, 1, 0, 32'h80, 0);
        step(1, 0, 0, 0, 0, 1, 0, 32'h80, 0);
        step(1, 0, 0, 0, 0, 1, 0, 32'h80, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a secondary write
        step(1, 0, 0, 0, 0, 1, 1, 32'h10, 32'hAA);
        step(0, 0, 0, 0, 0, 1, 1, 32'h10, 32'hAA);
        chk("rst_no_write", dmem[4], 32'hC0DE_0004);
        step(1, 0, 0, 0, 0, 1, 1, 32'h10, 32'hAA);
        step(1, 0, 0, 0, 0, 1, 1, 32'h10, 32'hAA);
        chk("post_rst_write", dmem[4], 32'hAA);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic: requests held until granted, occasional reset
        c_pend = 0; d_pend = 0;
        rcw = 0; rdw = 0; rca = 0; rcd = 0; rda = 0; rdd = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!c_pend && $urandom_range(0, 3) != 0) begin
                c_pend = 1;
                rcw = 1'($urandom_range(0, 1));
                rca = $urandom & 32'hF000_00FC;
                rcd = $urandom;
            end
            if (!d_pend && $urandom_range(0, 1) != 0) begin
                d_pend = 1;
                rdw = 1'($urandom_range(0, 1));
                rda = $urandom & 32'hF000_00FC;
                rdd = $urandom;
            end
            rrst = ($urandom_range(0, 63) != 0);
            step(rrst, c_pend, rcw, rca, rcd, d_pend, rdw, rda, rdd);
            if (last_cg) c_pend = 0;
            if (last_dg) d_pend = 0;
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        for (int i = 0; i < 256; i++)
            chk("mem_final", dmem[i], ref_mem[i]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
